// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared defaults and write-back select encodings for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RD_W     = 5;
  localparam int DEF_WB_SEL_W = 2;
  localparam int DEF_CNT_W    = 16;

  localparam int WB_ALU = 0;
  localparam int WB_MEM = 1;
  localparam int WB_PC  = 2;

endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// EX-side payload and registered MEM-side copies of the EX/MEM stage register.
interface ex_mem_stage_reg_if
  import ex_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_W     = DEF_RD_W,
  parameter int WB_SEL_W = DEF_WB_SEL_W
) ();

  logic                in_valid;
  logic [DATA_W-1:0]   in_alu_result;
  logic [DATA_W-1:0]   in_store_data;
  logic [DATA_W-1:0]   in_pc;
  logic [RD_W-1:0]     in_rd;
  logic                in_mem_write;
  logic                in_mem_read;
  logic                in_reg_write;
  logic [WB_SEL_W-1:0] in_wb_sel;

  logic                out_valid;
  logic [DATA_W-1:0]   out_alu_result;
  logic [DATA_W-1:0]   out_store_data;
  logic [DATA_W-1:0]   out_pc;
  logic [RD_W-1:0]     out_rd;
  logic                out_mem_write;
  logic                out_mem_read;
  logic                out_reg_write;
  logic [WB_SEL_W-1:0] out_wb_sel;
  logic                out_held;

  modport master (
    output in_valid, in_alu_result, in_store_data, in_pc, in_rd,
           in_mem_write, in_mem_read, in_reg_write, in_wb_sel,
    input  out_valid, out_alu_result, out_store_data, out_pc, out_rd,
           out_mem_write, out_mem_read, out_reg_write, out_wb_sel, out_held
  );

  modport slave (
    input  in_valid, in_alu_result, in_store_data, in_pc, in_rd,
           in_mem_write, in_mem_read, in_reg_write, in_wb_sel,
    output out_valid, out_alu_result, out_store_data, out_pc, out_rd,
           out_mem_write, out_mem_read, out_reg_write, out_wb_sel, out_held
  );

endinterface

// File: rtl/ex_mem_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with flush > stall > load priority.
// Optional stall-cycle counter is built when EX_MEM_STALL_CNT_EN is defined.
module ex_mem_stage_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_W     = DEF_RD_W,
  parameter int WB_SEL_W = DEF_WB_SEL_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  input logic               stall,
  input logic               flush,
  ex_mem_stage_reg_if.slave bus
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic                valid_q,      valid_d;
  logic [DATA_W-1:0]   alu_result_q, alu_result_d;
  logic [DATA_W-1:0]   store_data_q, store_data_d;
  logic [DATA_W-1:0]   pc_q,         pc_d;
  logic [RD_W-1:0]     rd_q,         rd_d;
  logic                mem_write_q,  mem_write_d;
  logic                mem_read_q,   mem_read_d;
  logic                reg_write_q,  reg_write_d;
  logic [WB_SEL_W-1:0] wb_sel_q,     wb_sel_d;
  logic                held_q,       held_d;

  always_comb begin
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    pc_d         = pc_q;
    rd_d         = rd_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    reg_write_d  = reg_write_q;
    wb_sel_d     = wb_sel_q;
    held_d       = 1'b0;
    if (flush) begin
      // Bubble: kill controls and destination, data fields keep their value
      valid_d     = 1'b0;
      rd_d        = '0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
      wb_sel_d    = WB_SEL_W'(WB_ALU);
    end else if (stall) begin
      held_d = valid_q;
    end else begin
      valid_d      = bus.in_valid;
      alu_result_d = bus.in_alu_result;
      store_data_d = bus.in_store_data;
      pc_d         = bus.in_pc;
      rd_d         = bus.in_rd;
      mem_write_d  = bus.in_mem_write & bus.in_valid;
      mem_read_d   = bus.in_mem_read  & bus.in_valid;
      reg_write_d  = bus.in_reg_write & bus.in_valid;
      wb_sel_d     = bus.in_wb_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      pc_q         <= '0;
      rd_q         <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      wb_sel_q     <= '0;
      held_q       <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      reg_write_q  <= reg_write_d;
      wb_sel_q     <= wb_sel_d;
      held_q       <= held_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_alu_result = alu_result_q;
  assign bus.out_store_data = store_data_q;
  assign bus.out_pc         = pc_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_mem_write  = mem_write_q;
  assign bus.out_mem_read   = mem_read_q;
  assign bus.out_reg_write  = reg_write_q;
  assign bus.out_wb_sel     = wb_sel_q;
  assign bus.out_held       = held_q;

`ifdef EX_MEM_STALL_CNT_EN
  logic stall_inc;
  assign stall_inc = stall & ~flush & valid_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed vector table, saturation/reset
// sequence and randomized traffic against a rule-level reference model.
module tb_ex_mem_stage_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 2;
  localparam int CW = 4;

  typedef struct packed {
    logic          rst_n, stall, flush, valid;
    logic [DW-1:0] alu, sd, pc;
    logic [RW-1:0] rd;
    logic          mw, mr, rw;
    logic [SW-1:0] wb;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu, sd, pc;
    logic [RW-1:0] rd;
    logic          mw, mr, rw;
    logic [SW-1:0] wb;
    logic          held;
    logic [CW-1:0] cnt;
  } st_t;

  typedef struct packed {
    in_t i;
    st_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, stall, flush;
  int   n_vec = 0;
  int   n_err = 0;
  st_t  model;

  always #5 clk = ~clk;

  ex_mem_stage_reg_if #(.DATA_W(DW), .RD_W(RW), .WB_SEL_W(SW)) bus ();

`ifdef EX_MEM_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  ex_mem_stage_reg #(.DATA_W(DW), .RD_W(RW), .WB_SEL_W(SW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic in_t mi(bit r, bit s, bit f, bit v, logic [DW-1:0] a, logic [DW-1:0] d,
                             logic [DW-1:0] p, logic [RW-1:0] rd, bit mw, bit mr, bit rw,
                             logic [SW-1:0] wb);
    in_t x;
    x.rst_n = r; x.stall = s; x.flush = f; x.valid = v;
    x.alu = a; x.sd = d; x.pc = p; x.rd = rd;
    x.mw = mw; x.mr = mr; x.rw = rw; x.wb = wb;
    return x;
  endfunction

  function automatic st_t ms(bit v, logic [DW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] p,
                             logic [RW-1:0] rd, bit mw, bit mr, bit rw, logic [SW-1:0] wb,
                             bit h, logic [CW-1:0] c);
    st_t x;
    x.valid = v; x.alu = a; x.sd = d; x.pc = p; x.rd = rd;
    x.mw = mw; x.mr = mr; x.rw = rw; x.wb = wb; x.held = h; x.cnt = c;
    return x;
  endfunction

  // Reference: what the MEM stage should hold after one edge, from the stage rules.
  function automatic st_t next_state(st_t s, in_t i);
    st_t n = s;
    n.held = 1'b0;
    if (!i.rst_n) begin
      n = '0;
    end else if (i.flush) begin
      n.valid = 0; n.rd = '0; n.mw = 0; n.mr = 0; n.rw = 0; n.wb = '0;
    end else if (i.stall) begin
      n.held = s.valid;
      if (s.valid && int'(s.cnt) < (1 << CW) - 1) n.cnt = s.cnt + 1'b1;
    end else begin
      n.valid = i.valid;
      n.alu = i.alu; n.sd = i.sd; n.pc = i.pc; n.rd = i.rd; n.wb = i.wb;
      n.mw = i.valid ? i.mw : 1'b0;
      n.mr = i.valid ? i.mr : 1'b0;
      n.rw = i.valid ? i.rw : 1'b0;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, st_t e);
    chk({tag, ".valid"},     64'(bus.out_valid),      64'(e.valid));
    chk({tag, ".alu"},       64'(bus.out_alu_result), 64'(e.alu));
    chk({tag, ".store"},     64'(bus.out_store_data), 64'(e.sd));
    chk({tag, ".pc"},        64'(bus.out_pc),         64'(e.pc));
    chk({tag, ".rd"},        64'(bus.out_rd),         64'(e.rd));
    chk({tag, ".mem_write"}, 64'(bus.out_mem_write),  64'(e.mw));
    chk({tag, ".mem_read"},  64'(bus.out_mem_read),   64'(e.mr));
    chk({tag, ".reg_write"}, 64'(bus.out_reg_write),  64'(e.rw));
    chk({tag, ".wb_sel"},    64'(bus.out_wb_sel),     64'(e.wb));
    chk({tag, ".held"},      64'(bus.out_held),       64'(e.held));
`ifdef EX_MEM_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, 64'(stall_cnt),          64'(e.cnt));
`endif
  endtask

  task automatic drive(in_t i);
    rst_n = i.rst_n; stall = i.stall; flush = i.flush;
    bus.in_valid = i.valid; bus.in_alu_result = i.alu; bus.in_store_data = i.sd;
    bus.in_pc = i.pc; bus.in_rd = i.rd; bus.in_mem_write = i.mw;
    bus.in_mem_read = i.mr; bus.in_reg_write = i.rw; bus.in_wb_sel = i.wb;
  endtask

  task automatic step_model(string tag, in_t i);
    drive(i);
    @(posedge clk);
    #1;
    model = next_state(model, i);
    check_all(tag, model);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{mi(0,1,0,1,32'hDEAD_BEEF,32'h1,32'h2,5'd31,1,1,1,2'd2),
                 ms(0,0,0,0,0,0,0,0,0,0,0)};
    vecs[1]  = '{mi(1,0,0,1,32'h1000_0004,32'h11,32'h100,5'd7,0,0,1,2'd0),
                 ms(1,32'h1000_0004,32'h11,32'h100,5'd7,0,0,1,2'd0,0,0)};
    vecs[2]  = '{mi(1,1,0,0,32'hFFFF,32'h77,32'h200,5'd3,1,1,0,2'd2),
                 ms(1,32'h1000_0004,32'h11,32'h100,5'd7,0,0,1,2'd0,1,1)};
    vecs[3]  = '{mi(1,1,0,1,32'hAAAA,32'h88,32'h300,5'd4,0,1,1,2'd1),
                 ms(1,32'h1000_0004,32'h11,32'h100,5'd7,0,0,1,2'd0,1,2)};
    vecs[4]  = '{mi(1,1,0,1,32'hBBBB,32'h99,32'h400,5'd6,1,0,0,2'd0),
                 ms(1,32'h1000_0004,32'h11,32'h100,5'd7,0,0,1,2'd0,1,3)};
    vecs[5]  = '{mi(1,0,0,1,32'h2000_0008,32'hCAFE,32'h104,5'd9,1,0,0,2'd0),
                 ms(1,32'h2000_0008,32'hCAFE,32'h104,5'd9,1,0,0,2'd0,0,3)};
    vecs[6]  = '{mi(1,1,1,1,32'h1234,32'h5678,32'h9ABC,5'd12,1,1,1,2'd2),
                 ms(0,32'h2000_0008,32'hCAFE,32'h104,5'd0,0,0,0,2'd0,0,3)};
    vecs[7]  = '{mi(1,0,0,0,32'h33,32'h44,32'h108,5'd5,1,1,1,2'd1),
                 ms(0,32'h33,32'h44,32'h108,5'd5,0,0,0,2'd1,0,3)};
    vecs[8]  = '{mi(1,1,0,1,32'h1,32'h2,32'h3,5'd1,1,1,1,2'd2),
                 ms(0,32'h33,32'h44,32'h108,5'd5,0,0,0,2'd1,0,3)};
    vecs[9]  = '{mi(1,0,0,1,32'h55,32'h66,32'h10C,5'd2,0,1,1,2'd1),
                 ms(1,32'h55,32'h66,32'h10C,5'd2,0,1,1,2'd1,0,3)};
    vecs[10] = '{mi(1,0,1,1,32'h77,32'h88,32'h110,5'd8,1,1,1,2'd2),
                 ms(0,32'h55,32'h66,32'h10C,5'd0,0,0,0,2'd0,0,3)};
    vecs[11] = '{mi(0,0,0,1,32'h99,32'hAA,32'hBB,5'd9,1,1,1,2'd3),
                 ms(0,0,0,0,0,0,0,0,0,0,0)};

    for (int k = 0; k < 12; k++) begin
      drive(vecs[k].i);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", k), vecs[k].e);
    end
    model = '0;

    // Counter saturation, then reset landing in the middle of a stall.
    step_model("sat_load", mi(1,0,0,1,32'hABCD,32'h1,32'h2,5'd3,1,0,1,2'd1));
    for (int k = 0; k < 20; k++) begin
      step_model($sformatf("sat%0d", k),
                 mi(1,1,0,1,$urandom,$urandom,$urandom,RW'($urandom),1,1,1,SW'($urandom)));
    end
`ifdef EX_MEM_STALL_CNT_EN
    chk("sat_final_cnt", 64'(stall_cnt), 64'd15);
`endif
    step_model("rst_mid_stall", mi(0,1,0,1,32'h1111,32'h2,32'h3,5'd4,1,1,1,2'd2));
    chk("rst_mid_stall.alu_zero", 64'(bus.out_alu_result), 64'd0);
    step_model("post_rst_stall", mi(1,1,0,1,32'h2222,32'h3,32'h4,5'd5,1,1,1,2'd2));
    step_model("post_rst_load", mi(1,0,0,1,32'h3333,32'h4,32'h5,5'd6,0,1,1,2'd1));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 2000; k++) begin
      in_t r;
      r.rst_n = ($urandom_range(0, 49) != 0);
      r.stall = ($urandom_range(0, 2) == 0);
      r.flush = ($urandom_range(0, 7) == 0);
      r.valid = ($urandom_range(0, 3) != 0);
      r.alu   = $urandom;
      r.sd    = $urandom;
      r.pc    = $urandom;
      r.rd    = RW'($urandom);
      r.mw    = 1'($urandom);
      r.mr    = 1'($urandom);
      r.rw    = 1'($urandom);
      r.wb    = SW'($urandom);
      step_model($sformatf("rnd%0d", k), r);
      if (!bus.out_valid && (bus.out_mem_write || bus.out_mem_read || bus.out_reg_write))
        chk($sformatf("rnd%0d.ctrl_without_valid", k), 64'd1, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_reg.md
EX_MEM_STAGE_REG -- requirements
Module: ex_mem_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result, store data and PC fields, SHALL be legal in 8..64.
REQ-002 Parameter RD_W, default 5, width of destination register index, SHALL be legal in 3..6.
REQ-003 Parameter WB_SEL_W, default 2, width of write-back select field.
REQ-004 Parameter CNT_W, default 16, width of stall counter, SHALL be legal in 4..32.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 stall  input  1  hold all stage contents this cycle.
REQ-008 flush  input  1  replace stage contents with a bubble this cycle.
REQ-009 in_valid  input  1  EX stage holds a real instruction.
REQ-010 in_alu_result, in_store_data, in_pc  input  DATA_W each  EX-stage payload.
REQ-011 in_rd  input  RD_W  destination register index.
REQ-012 in_mem_write, in_mem_read, in_reg_write  input  1 each  MEM/WB controls.
REQ-013 in_wb_sel  input  WB_SEL_W  write-back source select.
REQ-014 out_valid, out_alu_result, out_store_data, out_pc, out_rd, out_mem_write, out_mem_read, out_reg_write, out_wb_sel  output  matching widths  registered MEM-stage copies.
REQ-015 out_held  output  1  registered; 1 when the previous edge was a stall hold of a valid entry.
REQ-016 stall_cnt  output  CNT_W  stall-cycle count; present only under the macro in REQ-029.

Function
REQ-017 Update priority at each edge SHALL be: reset > flush > stall > load.
REQ-018 Load (no flush, no stall): every out_* SHALL take its in_* value, latency exactly one cycle.
REQ-019 Stall (no flush): every out_* SHALL keep its current value; in_* ignored.
REQ-020 Flush: out_valid, out_mem_write, out_mem_read, out_reg_write SHALL become 0 and out_wb_sel SHALL become 0; out_rd SHALL become 0; data fields (alu_result, store_data, pc) SHALL hold.
REQ-021 Flush asserted together with stall SHALL flush (bubble overrides hold).
REQ-022 Load with in_valid=0 SHALL force out_mem_write, out_mem_read, out_reg_write to 0 regardless of their inputs; data fields load normally.
REQ-023 Control outputs SHALL never be 1 while out_valid is 0.
REQ-024 out_held SHALL be 1 after an edge with stall=1, flush=0, out_valid=1, else 0.
REQ-025 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 Edge with rst_n=0 SHALL clear every output, including data fields, out_held and stall_cnt, to 0, irrespective of stall/flush.
REQ-027 Reset asserted during a stall SHALL discard the held entry; first edge after rst_n rises SHALL obey REQ-017 normally.

Configuration
REQ-028 Stall counting SHALL be compiled in only when macro EX_MEM_STALL_CNT_EN is defined.
REQ-029 With EX_MEM_STALL_CNT_EN: stall_cnt SHALL increment by 1 on each edge with stall=1, flush=0, out_valid=1, SHALL saturate at all-ones (no wrap), cleared only by reset.
REQ-030 Without EX_MEM_STALL_CNT_EN: port stall_cnt and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package ex_mem_pkg SHALL hold default widths (DATA_W, RD_W, WB_SEL_W, CNT_W) and wb_sel encodings: WB_ALU=0, WB_MEM=1, WB_PC=2.
REQ-032 Saturating counter SHALL be a sub-module sat_counter (params W; ports clk, rst_n, inc, count).
REQ-033 Top SHALL instantiate sat_counter only under EX_MEM_STALL_CNT_EN.

Verification
REQ-034 Reset then load in_valid=1, alu=0x1000_0004, rd=7, reg_write=1 -> next cycle out_alu_result=0x1000_0004, out_rd=7, out_reg_write=1, out_valid=1.
REQ-035 Valid entry loaded, stall=1 for 3 cycles while inputs change -> outputs unchanged, out_held=1 each cycle, stall_cnt=3 (macro on).
REQ-036 Valid store entry (mem_write=1) then flush=1 and stall=1 same cycle -> out_valid=0, out_mem_write=0, out_rd=0, out_alu_result unchanged, out_held=0.
REQ-037 Load in_valid=0 with in_mem_write=1, in_reg_write=1 -> out_mem_write=0, out_reg_write=0, out_valid=0.
REQ-038 CNT_W=4, macro on, 20 consecutive valid stall cycles -> stall_cnt stops at 15; then rst_n=0 mid-stall -> all outputs 0 next edge.
REQ-039 Macro off build -> stall_cnt port absent; REQ-034..037 pass unchanged.
